// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake, strobe and counter bundle between the multicycle controller and its datapath/memories
interface multicycle_ctrl_if #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3
);
    logic [INSTR_W-1:0] instr;
    logic               imem_req;
    logic               imem_ready;
    logic               dmem_ready;
    logic               flag_z;
    logic               flag_n;
    logic               ir_load;
    logic [REG_W-1:0]   rd_sel_a;
    logic [REG_W-1:0]   rd_sel_b;
    logic [REG_W-1:0]   wr_sel;
    logic [DATA_W-1:0]  imm;
    logic [1:0]         alu_op;
    logic               alu_src;
    logic               flag_write;
    logic               reg_write;
    logic               mem2reg;
    logic               link_write;
    logic               dmem_req;
    logic               mem_read;
    logic               mem_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               instr_retired;
    logic               illegal;
    logic [31:0]        cycle_count;
    logic [31:0]        retire_count;

    modport master (
        input  instr, imem_ready, dmem_ready, flag_z, flag_n,
        output imem_req, ir_load, rd_sel_a, rd_sel_b, wr_sel, imm, alu_op, alu_src,
               flag_write, reg_write, mem2reg, link_write, dmem_req, mem_read, mem_write,
               pc_write, pc_src, instr_retired, illegal, cycle_count, retire_count
    );

    modport slave (
        output instr, imem_ready, dmem_ready, flag_z, flag_n,
        input  imem_req, ir_load, rd_sel_a, rd_sel_b, wr_sel, imm, alu_op, alu_src,
               flag_write, reg_write, mem2reg, link_write, dmem_req, mem_read, mem_write,
               pc_write, pc_src, instr_retired, illegal, cycle_count, retire_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with illegal-opcode trap; CTRL_PERF_EN adds cycle/retire counters
module multicycle_ctrl #(
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3
) (
    input logic              clk,
    input logic              reset_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [REG_W-1:0] LINK = '1;

    state_t             r_state, w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [3:0]         w_code;
    logic               w_i, w_alu, w_ld, w_st, w_jmp, w_call, w_legal, w_taken, w_mem;
    logic [REG_W-1:0]   w_rx, w_ry;
    logic [DATA_W-1:0]  w_imm;
    logic [1:0]         w_tgt;

    assign w_code  = r_ir[3:0];
    assign w_i     = r_ir[4];
    assign w_rx    = r_ir[5 +: REG_W];
    assign w_ry    = r_ir[5+REG_W +: REG_W];
    assign w_imm   = DATA_W'($signed(r_ir[INSTR_W-1:5+REG_W]));
    assign w_alu   = w_code[3:2] == 2'b00;
    assign w_ld    = w_code == 4'd4;
    assign w_st    = w_code == 4'd5;
    assign w_jmp   = w_code == 4'd8 || w_code == 4'd9 || w_code == 4'd10;
    assign w_call  = w_code == 4'd12;
    assign w_mem   = w_ld | w_st;
    assign w_legal = w_alu | w_mem | w_jmp | w_call;
    assign w_taken = w_code == 4'd8 || (w_code == 4'd9 && bus.flag_z) || (w_code == 4'd10 && bus.flag_n) || w_call;
    assign w_tgt   = w_i ? 2'b10 : 2'b01;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_RST;
        else          r_state <= w_next;
    end

    // instruction register, captured on the completing fetch cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                r_ir <= '0;
        else if (r_state == S_FETCH && bus.imem_ready) r_ir <= bus.instr;
    end

    // next state and per-state datapath strobes
    always_comb begin
        w_next            = r_state;
        bus.imem_req      = 1'b0;
        bus.ir_load       = 1'b0;
        bus.rd_sel_a      = '0;
        bus.rd_sel_b      = '0;
        bus.wr_sel        = '0;
        bus.imm           = '0;
        bus.alu_op        = 2'b00;
        bus.alu_src       = 1'b0;
        bus.flag_write    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mem2reg       = 1'b0;
        bus.link_write    = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_src        = 2'b00;
        bus.instr_retired = 1'b0;
        bus.illegal       = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
                w_next       = bus.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.rd_sel_a = w_rx;
                bus.rd_sel_b = w_ry;
                bus.imm      = w_imm;
                w_next       = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (w_alu) begin
                    bus.reg_write  = w_code != 4'd3;
                    bus.wr_sel     = w_rx;
                    bus.alu_op     = w_code == 4'd0 ? 2'b00 : w_code == 4'd1 ? 2'b01 : 2'b10;
                    bus.alu_src    = w_i;
                    bus.flag_write = w_code != 4'd0;
                end
                if (w_call) begin
                    bus.link_write = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.wr_sel     = LINK;
                end
                if (w_jmp | w_call) bus.pc_src = w_taken ? w_tgt : 2'b00;
                if (w_mem) begin
                    bus.alu_op  = 2'b01;
                    bus.alu_src = 1'b1;
                end
                bus.pc_write      = !w_mem;
                bus.instr_retired = !w_mem;
                w_next            = w_mem ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                bus.dmem_req      = 1'b1;
                bus.mem_read      = w_ld;
                bus.mem_write     = w_st;
                bus.pc_write      = w_st & bus.dmem_ready;
                bus.instr_retired = w_st & bus.dmem_ready;
                w_next            = !bus.dmem_ready ? S_MEM : w_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                bus.reg_write     = 1'b1;
                bus.mem2reg       = 1'b1;
                bus.wr_sel        = w_rx;
                bus.pc_write      = 1'b1;
                bus.instr_retired = 1'b1;
                w_next            = S_FETCH;
            end
            S_TRAP: bus.illegal = 1'b1;
            default: w_next = S_RST;
        endcase
    end

`ifdef CTRL_PERF_EN
    logic [31:0] r_cycle_count, r_retire_count;

    // performance counters: active cycles and retired instructions, wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_count  <= '0;
            r_retire_count <= '0;
        end else begin
            if (r_state != S_RST && r_state != S_TRAP) r_cycle_count <= r_cycle_count + 32'd1;
            if (bus.instr_retired) r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign bus.cycle_count  = r_cycle_count;
    assign bus.retire_count = r_retire_count;
`else
    assign bus.cycle_count  = '0;
    assign bus.retire_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle vector table for multicycle_ctrl plus async-reset and counter sequences
module tb_multicycle_ctrl;
    typedef struct packed {
        logic        imem_req, ir_load, dmem_req, mem_read, mem_write, reg_write, mem2reg;
        logic        link_write, flag_write, alu_src, pc_write, instr_retired, illegal;
        logic [1:0]  alu_op, pc_src;
        logic [2:0]  rd_a, rd_b, wr_sel;
        logic [15:0] imm;
    } out_t;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [15:0] instr;
        logic        imr, dmr, fz, fn;
        out_t        exp;
    } vec_t;

    localparam logic [15:0] ADD  = 16'h0341;
    localparam logic [15:0] SUBI = 16'hFE32;
    localparam logic [15:0] MVI  = 16'hFFD0;
    localparam logic [15:0] CMP  = 16'h0143;
    localparam logic [15:0] JZ   = 16'h0419;
    localparam logic [15:0] JNR  = 16'h00AA;
    localparam logic [15:0] CALL = 16'h101C;
    localparam logic [15:0] LD   = 16'h0164;
    localparam logic [15:0] ST   = 16'h0285;
    localparam logic [15:0] ILL  = 16'h000F;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    out_t act;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTR_W(16), .DATA_W(16), .REG_W(3)) bus();

    multicycle_ctrl #(.INSTR_W(16), .DATA_W(16), .REG_W(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    assign act = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.mem_read, bus.mem_write, bus.reg_write,
                  bus.mem2reg, bus.link_write, bus.flag_write, bus.alu_src, bus.pc_write,
                  bus.instr_retired, bus.illegal, bus.alu_op, bus.pc_src, bus.rd_sel_a,
                  bus.rd_sel_b, bus.wr_sel, bus.imm};

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic out_t FE(logic rdy);
        out_t e = '0;
        e.imem_req = 1'b1;
        e.ir_load  = rdy;
        return e;
    endfunction

    function automatic out_t DE(logic [2:0] a, logic [2:0] b, logic [15:0] i);
        out_t e = '0;
        e.rd_a = a;
        e.rd_b = b;
        e.imm  = i;
        return e;
    endfunction

    function automatic out_t EX(logic rw, logic [2:0] wr, logic [1:0] op, logic src, logic fw,
                                logic pcw, logic [1:0] pcs, logic lw);
        out_t e = '0;
        e.reg_write     = rw;
        e.wr_sel        = wr;
        e.alu_op        = op;
        e.alu_src       = src;
        e.flag_write    = fw;
        e.pc_write      = pcw;
        e.instr_retired = pcw;
        e.pc_src        = pcs;
        e.link_write    = lw;
        return e;
    endfunction

    function automatic out_t MM(logic rd, logic wr, logic done);
        out_t e = '0;
        e.dmem_req      = 1'b1;
        e.mem_read      = rd;
        e.mem_write     = wr;
        e.pc_write      = done;
        e.instr_retired = done;
        return e;
    endfunction

    function automatic out_t WB(logic [2:0] wr);
        out_t e = '0;
        e.reg_write     = 1'b1;
        e.mem2reg       = 1'b1;
        e.wr_sel        = wr;
        e.pc_write      = 1'b1;
        e.instr_retired = 1'b1;
        return e;
    endfunction

    function automatic out_t TR();
        out_t e = '0;
        e.illegal = 1'b1;
        return e;
    endfunction

    task automatic add(string n, logic rn, logic [15:0] ins, logic imr, logic dmr, logic fz, logic fn, out_t e);
        vec_t v;
        v.name  = n;
        v.rst_n = rn;
        v.instr = ins;
        v.imr   = imr;
        v.dmr   = dmr;
        v.fz    = fz;
        v.fn    = fn;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    initial begin
        bus.instr      = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.flag_z     = 1'b0;
        bus.flag_n     = 1'b0;

        add("rst_low",     0, 16'h0, 0, 0, 0, 0, '0);
        add("rst_state",   1, 16'h0, 0, 0, 0, 0, '0);
        add("add_fetch",   1, ADD,   1, 0, 0, 0, FE(1));
        add("add_dec",     1, ADD,   0, 0, 0, 0, DE(3'd2, 3'd3, 16'h0003));
        add("add_exec",    1, ADD,   0, 0, 0, 0, EX(1, 3'd2, 2'b01, 0, 1, 1, 2'b00, 0));
        for (int k = 0; k < 3; k++) add("subi_wait", 1, SUBI, 0, 0, 0, 0, FE(0));
        add("subi_fetch",  1, SUBI,  1, 0, 0, 0, FE(1));
        add("subi_dec",    1, SUBI,  0, 0, 0, 0, DE(3'd1, 3'd6, 16'hFFFE));
        add("subi_exec",   1, SUBI,  0, 0, 0, 0, EX(1, 3'd1, 2'b10, 1, 1, 1, 2'b00, 0));
        add("mvi_fetch",   1, MVI,   1, 0, 0, 0, FE(1));
        add("mvi_dec",     1, MVI,   0, 0, 0, 0, DE(3'd6, 3'd7, 16'hFFFF));
        add("mvi_exec",    1, MVI,   0, 0, 0, 0, EX(1, 3'd6, 2'b00, 1, 0, 1, 2'b00, 0));
        add("cmp_fetch",   1, CMP,   1, 0, 0, 0, FE(1));
        add("cmp_dec",     1, CMP,   0, 0, 0, 0, DE(3'd2, 3'd1, 16'h0001));
        add("cmp_exec",    1, CMP,   0, 0, 0, 0, EX(0, 3'd2, 2'b10, 0, 1, 1, 2'b00, 0));
        add("jz_nt_fetch", 1, JZ,    1, 0, 0, 0, FE(1));
        add("jz_nt_dec",   1, JZ,    0, 0, 0, 0, DE(3'd0, 3'd4, 16'h0004));
        add("jz_nt_exec",  1, JZ,    0, 0, 0, 1, EX(0, 3'd0, 2'b00, 0, 0, 1, 2'b00, 0));
        add("jz_t_fetch",  1, JZ,    1, 0, 0, 0, FE(1));
        add("jz_t_dec",    1, JZ,    0, 0, 0, 0, DE(3'd0, 3'd4, 16'h0004));
        add("jz_t_exec",   1, JZ,    0, 0, 1, 0, EX(0, 3'd0, 2'b00, 0, 0, 1, 2'b10, 0));
        add("jnr_fetch",   1, JNR,   1, 0, 0, 0, FE(1));
        add("jnr_dec",     1, JNR,   0, 0, 0, 0, DE(3'd5, 3'd0, 16'h0000));
        add("jnr_exec",    1, JNR,   0, 0, 0, 1, EX(0, 3'd0, 2'b00, 0, 0, 1, 2'b01, 0));
        add("call_fetch",  1, CALL,  1, 0, 0, 0, FE(1));
        add("call_dec",    1, CALL,  0, 0, 0, 0, DE(3'd0, 3'd0, 16'h0010));
        add("call_exec",   1, CALL,  0, 0, 0, 0, EX(1, 3'd7, 2'b00, 0, 0, 1, 2'b10, 1));
        add("ld_fetch",    1, LD,    1, 0, 0, 0, FE(1));
        add("ld_dec",      1, LD,    0, 0, 0, 0, DE(3'd3, 3'd1, 16'h0001));
        add("ld_exec",     1, LD,    0, 0, 0, 0, EX(0, 3'd0, 2'b01, 1, 0, 0, 2'b00, 0));
        add("ld_mem_wait", 1, LD,    0, 0, 0, 0, MM(1, 0, 0));
        add("ld_mem_wait", 1, LD,    0, 0, 0, 0, MM(1, 0, 0));
        add("ld_mem_rdy",  1, LD,    0, 1, 0, 0, MM(1, 0, 0));
        add("ld_wb",       1, LD,    0, 0, 0, 0, WB(3'd3));
        add("st_fetch",    1, ST,    1, 0, 0, 0, FE(1));
        add("st_dec",      1, ST,    0, 0, 0, 0, DE(3'd4, 3'd2, 16'h0002));
        add("st_exec",     1, ST,    0, 0, 0, 0, EX(0, 3'd0, 2'b01, 1, 0, 0, 2'b00, 0));
        add("st_mem_rdy",  1, ST,    0, 1, 0, 0, MM(0, 1, 1));
        add("st_no_wb",    1, ILL,   0, 0, 0, 0, FE(0));
        add("ill_fetch",   1, ILL,   1, 0, 0, 0, FE(1));
        add("ill_dec",     1, ILL,   0, 0, 0, 0, DE(3'd0, 3'd0, 16'h0000));
        for (int k = 0; k < 10; k++) add("ill_trap", 1, ILL, 1, 1, 1, 1, TR());

        foreach (vecs[k]) begin
            @(negedge clk);
            reset_n        = vecs[k].rst_n;
            bus.instr      = vecs[k].instr;
            bus.imem_ready = vecs[k].imr;
            bus.dmem_ready = vecs[k].dmr;
            bus.flag_z     = vecs[k].fz;
            bus.flag_n     = vecs[k].fn;
            #1;
            check(vecs[k].name, 64'(act), 64'(vecs[k].exp));
        end

        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_clears_trap", 64'(act), 64'(0));

        @(negedge clk);
        reset_n        = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        @(posedge clk);
        #2;
        check("fetch_req_held", 64'(bus.imem_req), 64'(1));
        reset_n = 1'b0;
        #1;
        check("rst_drops_imem_req", 64'(bus.imem_req), 64'(0));

        @(negedge clk);
        reset_n        = 1'b1;
        bus.instr      = LD;
        bus.imem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("ld_dmem_req_up", 64'(bus.dmem_req), 64'(1));
        reset_n = 1'b0;
        #1;
        check("rst_drops_dmem_req", 64'(bus.dmem_req), 64'(0));

        @(negedge clk);
        reset_n        = 1'b1;
        bus.instr      = ADD;
        bus.imem_ready = 1'b1;
        repeat (10) @(posedge clk);
        #2;
`ifdef CTRL_PERF_EN
        check("cycle_count", 64'(bus.cycle_count), 64'(9));
        check("retire_count", 64'(bus.retire_count), 64'(3));
`else
        check("cycle_count_off", 64'(bus.cycle_count), 64'(0));
        check("retire_count_off", 64'(bus.retire_count), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
